// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared definitions for the stochastic-computing stages
package sc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } sc_state_e;

    localparam int SC_LOG_LEN_DEFAULT = 8;

    // A full window of ones needs one bit more than the window index.
    function automatic int sc_count_width(input int log_len);
        return log_len + 1;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// rtl/sc_window_counter.sv - qualified-bit and ones accumulation with completion strobe
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int LOG_LEN = SC_LOG_LEN_DEFAULT,
    parameter int CNT_W   = sc_count_width(LOG_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             done,
    output logic [CNT_W-1:0] result
);

    logic [LOG_LEN-1:0] bit_cnt;
    logic [CNT_W-1:0]   ones_cnt;
    logic [CNT_W-1:0]   bit_ext;

    assign bit_ext = {{(CNT_W-1){1'b0}}, in_bit};

    // The final qualified bit is folded into the result combinationally.
    assign done   = enable && in_valid && (&bit_cnt);
    assign result = ones_cnt + bit_ext;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else if (done) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else if (enable && in_valid) begin
            bit_cnt  <= bit_cnt + 1'b1;
            ones_cnt <= ones_cnt + bit_ext;
        end
    end

endmodule

// File: rtl/sc_stream_decoder.sv
// rtl/sc_stream_decoder.sv - stochastic stream to binary ones-count converter
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int LOG_LEN    = SC_LOG_LEN_DEFAULT,
    parameter int CONTINUOUS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_bit,
    input  logic               in_valid,
    output logic [LOG_LEN:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overrun,
    input  logic               clr_overrun,
    output logic               busy
);

    localparam int CNT_W = sc_count_width(LOG_LEN);
    localparam sc_state_e RESET_STATE = (CONTINUOUS != 0) ? ST_COUNT : ST_IDLE;

    sc_state_e        state_q, state_d;
    logic             done;
    logic [CNT_W-1:0] result;
    logic             counting;

    assign counting = (state_q == ST_COUNT);
    assign busy     = counting;

    sc_window_counter #(
        .LOG_LEN (LOG_LEN),
        .CNT_W   (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .enable   (counting),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .done     (done),
        .result   (result)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (done) begin
                    state_d = (CONTINUOUS != 0) ? ST_COUNT : ST_IDLE;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // A consumer draining the register on the completing edge frees it for the new result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (done && (!out_valid || out_ready)) begin
                out_data  <= result;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (done && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb/tb_sc_stream_decoder.sv - bench for sc_stream_decoder, continuous and one-shot instances
module tb_sc_stream_decoder;

    localparam int LOG_LEN = 4;
    localparam int WIN     = 1 << LOG_LEN;

    logic clk = 1'b0;
    logic rst, start, in_bit, in_valid, out_ready, clr_overrun;

    logic [LOG_LEN:0] a_out_data, b_out_data;
    logic             a_out_valid, b_out_valid;
    logic             a_overrun, b_overrun;
    logic             a_busy, b_busy;

    int n_pass   = 0;
    int n_checks = 0;

    // Reference: index 0 is the continuous instance, index 1 the one-shot.
    int   m_cnt [2];
    int   m_ones[2];
    int   m_data[2];
    logic m_busy[2];
    logic m_valid[2];
    logic m_ovr[2];

    always #5 clk = ~clk;

    sc_stream_decoder #(.LOG_LEN(LOG_LEN), .CONTINUOUS(1)) u_cont (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .out_data    (a_out_data),
        .out_valid   (a_out_valid),
        .out_ready   (out_ready),
        .overrun     (a_overrun),
        .clr_overrun (clr_overrun),
        .busy        (a_busy)
    );

    sc_stream_decoder #(.LOG_LEN(LOG_LEN), .CONTINUOUS(0)) u_shot (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .out_data    (b_out_data),
        .out_valid   (b_out_valid),
        .out_ready   (out_ready),
        .overrun     (b_overrun),
        .clr_overrun (clr_overrun),
        .busy        (b_busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic done, set_ovr;
            int   res;
            done    = 1'b0;
            set_ovr = 1'b0;
            res     = 0;
            if (!rst) begin
                m_busy[i]  = (i == 0);
                m_cnt[i]   = 0;
                m_ones[i]  = 0;
                m_data[i]  = 0;
                m_valid[i] = 1'b0;
                m_ovr[i]   = 1'b0;
            end else begin
                if (!m_busy[i]) begin
                    if (start) m_busy[i] = 1'b1;
                end else if (in_valid) begin
                    m_cnt[i]++;
                    m_ones[i] += int'(in_bit);
                    if (m_cnt[i] == WIN) begin
                        done      = 1'b1;
                        res       = m_ones[i];
                        m_cnt[i]  = 0;
                        m_ones[i] = 0;
                        m_busy[i] = (i == 0);
                    end
                end
                if (done && (!m_valid[i] || out_ready)) begin
                    m_data[i]  = res;
                    m_valid[i] = 1'b1;
                end else if (done) begin
                    set_ovr = 1'b1;
                end else if (m_valid[i] && out_ready) begin
                    m_valid[i] = 1'b0;
                end
                if (set_ovr) m_ovr[i] = 1'b1;
                else if (clr_overrun) m_ovr[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("a_data",    8'(a_out_data),  8'(m_data[0]));
        chk("a_valid",   8'(a_out_valid), 8'(m_valid[0]));
        chk("a_overrun", 8'(a_overrun),   8'(m_ovr[0]));
        chk("a_busy",    8'(a_busy),      8'(m_busy[0]));
        chk("b_data",    8'(b_out_data),  8'(m_data[1]));
        chk("b_valid",   8'(b_out_valid), 8'(m_valid[1]));
        chk("b_overrun", 8'(b_overrun),   8'(m_ovr[1]));
        chk("b_busy",    8'(b_busy),      8'(m_busy[1]));
    endtask

    task automatic tick(input logic s, input logic b, input logic v,
                        input logic r, input logic c, input logic rs);
        start       = s;
        in_bit      = b;
        in_valid    = v;
        out_ready   = r;
        clr_overrun = c;
        rst         = rs;
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    function automatic logic [WIN-1:0] rand_pat(input int k);
        logic [WIN-1:0] p;
        p = '0;
        while ($countones(p) < k) p[$urandom_range(WIN-1, 0)] = 1'b1;
        return p;
    endfunction

    // Sixteen back-to-back qualified bits; ready for the last one is given separately.
    task automatic feed_window(input logic [WIN-1:0] p, input logic r, input logic r_last);
        for (int i = 0; i < WIN - 1; i++) tick(1'b0, p[i], 1'b1, r, 1'b0, 1'b1);
        tick(1'b0, p[WIN-1], 1'b1, r_last, 1'b0, 1'b1);
    endtask

    initial begin
        logic [WIN-1:0] p;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ones[i] = 0; m_data[i] = 0;
            m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
        end

        for (int i = 0; i < 4; i++) begin
            tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            chk("rst_valid", 8'(a_out_valid), 8'd0);
            chk("rst_ovr",   8'(a_overrun),   8'd0);
            chk("rst_data",  8'(a_out_data),  8'd0);
        end

        p = 16'h5555;
        feed_window(p, 1'b1, 1'b1);
        chk("alt_valid", 8'(a_out_valid), 8'd1);
        chk("alt_data",  8'(a_out_data),  8'd8);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("alt_drop",  8'(a_out_valid), 8'd0);

        feed_window(16'hFFFF, 1'b1, 1'b1);
        chk("ones_data", 8'(a_out_data), 8'd16);
        feed_window(16'h0000, 1'b1, 1'b1);
        chk("zero_data", 8'(a_out_data), 8'd0);
        chk("zero_valid", 8'(a_out_valid), 8'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        p = rand_pat(5);
        for (int i = 0; i < 2 * WIN; i++) begin
            tick(1'b0, (i % 2 == 0) ? p[i/2] : 1'($urandom), (i % 2 == 0), 1'b1, 1'b0, 1'b1);
            if (i == 2 * WIN - 3) chk("gap_early", 8'(a_out_valid), 8'd0);
            if (i == 2 * WIN - 2) begin
                chk("gap_valid", 8'(a_out_valid), 8'd1);
                chk("gap_data",  8'(a_out_data),  8'd5);
            end
        end

        feed_window(rand_pat(3), 1'b0, 1'b0);
        chk("bp_first", 8'(a_out_data), 8'd3);
        feed_window(rand_pat(11), 1'b0, 1'b0);
        chk("bp_hold",  8'(a_out_data), 8'd3);
        chk("bp_ovr",   8'(a_overrun),  8'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("bp_accept", 8'(a_out_valid), 8'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("bp_clr",    8'(a_overrun),   8'd0);

        feed_window(rand_pat(7), 1'b0, 1'b0);
        chk("sim_first", 8'(a_out_data), 8'd7);
        feed_window(rand_pat(12), 1'b0, 1'b1);
        chk("sim_data",  8'(a_out_data),  8'd12);
        chk("sim_valid", 8'(a_out_valid), 8'd1);
        chk("sim_ovr",   8'(a_overrun),   8'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("shot_busy", 8'(b_busy), 8'd1);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("shot_rst_busy",  8'(b_busy),      8'd0);
        chk("shot_rst_valid", 8'(b_out_valid), 8'd0);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        feed_window(16'hFFFF, 1'b1, 1'b1);
        chk("shot_data",  8'(b_out_data),  8'd16);
        chk("shot_valid", 8'(b_out_valid), 8'd1);
        chk("shot_idle",  8'(b_busy),      8'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("shot_stay_idle", 8'(b_busy), 8'd0);

        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(7, 0) == 0), 1'($urandom), ($urandom_range(3, 0) != 0),
                 ($urandom_range(3, 0) != 0), ($urandom_range(7, 0) == 0),
                 ($urandom_range(63, 0) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
